// File: rtl/data_mem_responder_if.sv
// Data-memory port between the CPU MEM stage (master) and the memory responder (slave).
interface data_mem_responder_if;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic [31:0] mem_din;
    logic        mem_stall;
    logic        mem_ack;
    logic        mem_err;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    modport master (
        output mem_ren, mem_wen, mem_addr, mem_dout,
        input  mem_din, mem_stall, mem_ack, mem_err, rd_count, wr_count
    );

    modport slave (
        input  mem_ren, mem_wen, mem_addr, mem_dout,
        output mem_din, mem_stall, mem_ack, mem_err, rd_count, wr_count
    );
endinterface

// File: rtl/data_mem_responder.sv
// Wait-stated word RAM responder for the CPU data port, with saturating access counters.
// Optional misaligned-access detection is enabled by defining DATA_MEM_ALIGN_CHECK_EN.
module data_mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    data_mem_responder_if.slave bus
);
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                  state_q;
    logic [3:0]              wait_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [31:0]             wdata_q;
    logic                    is_write_q;
    logic [31:0]             din_q;
    logic                    ack_q;
    logic                    err_q;
    logic [15:0]             rd_cnt_q;
    logic [15:0]             wr_cnt_q;
    logic [31:0]             ram [2**ADDR_WIDTH];

    logic                    req;
    logic                    in_idle;
    logic                    commit;
    logic [ADDR_WIDTH-1:0]   cur_idx;
    logic [31:0]             cur_wdata;
    logic                    cur_write;
    logic                    cur_mis;
    logic                    live_mis;

    logic unused_addr;
    assign unused_addr = ^{bus.mem_addr[31:ADDR_WIDTH+2], bus.mem_addr[1:0]};

    assign req     = bus.mem_ren | bus.mem_wen;
    assign in_idle = (state_q == StIdle);

`ifdef DATA_MEM_ALIGN_CHECK_EN
    logic mis_q;
    assign live_mis = (bus.mem_addr[1:0] != 2'b00);
    assign cur_mis  = in_idle ? live_mis : mis_q;
`else
    assign live_mis = 1'b0;
    assign cur_mis  = 1'b0;
`endif

    // With zero wait states the access commits straight out of IDLE using the live request.
    assign cur_idx   = in_idle ? bus.mem_addr[ADDR_WIDTH+1:2] : idx_q;
    assign cur_wdata = in_idle ? bus.mem_dout : wdata_q;
    assign cur_write = in_idle ? bus.mem_wen : is_write_q;

    always_comb begin
        commit = 1'b0;
        if (rst_n) begin
            if (state_q == StWait && wait_q == 4'd0) begin
                commit = 1'b1;
            end else if (in_idle && req && WAIT_STATES == 0) begin
                commit = 1'b1;
            end
        end
    end

    assign bus.mem_stall = rst_n & ((in_idle & req) | (state_q == StWait));
    assign bus.mem_din   = din_q;
    assign bus.mem_ack   = ack_q;
    assign bus.mem_err   = err_q;
    assign bus.rd_count  = rd_cnt_q;
    assign bus.wr_count  = wr_cnt_q;

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (commit && cur_write && !cur_mis) begin
            ram[cur_idx] <= cur_wdata;
        end
    end

`ifdef DATA_MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mis_q <= 1'b0;
        end else if (in_idle && req) begin
            mis_q <= live_mis;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            wait_q     <= 4'd0;
            idx_q      <= '0;
            wdata_q    <= 32'd0;
            is_write_q <= 1'b0;
            din_q      <= 32'd0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rd_cnt_q   <= 16'd0;
            wr_cnt_q   <= 16'd0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            if (commit) begin
                ack_q <= 1'b1;
                err_q <= cur_mis;
                if (cur_write) begin
                    if (!cur_mis && wr_cnt_q != 16'hFFFF) begin
                        wr_cnt_q <= wr_cnt_q + 16'd1;
                    end
                end else begin
                    din_q <= cur_mis ? 32'd0 : ram[cur_idx];
                    if (!cur_mis && rd_cnt_q != 16'hFFFF) begin
                        rd_cnt_q <= rd_cnt_q + 16'd1;
                    end
                end
            end
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        idx_q      <= bus.mem_addr[ADDR_WIDTH+1:2];
                        wdata_q    <= bus.mem_dout;
                        is_write_q <= bus.mem_wen;
                        if (WAIT_STATES == 0) begin
                            state_q <= StResp;
                        end else begin
                            state_q <= StWait;
                            wait_q  <= WAIT_INIT;
                        end
                    end
                end
                StWait: begin
                    if (wait_q == 4'd0) begin
                        state_q <= StResp;
                    end else begin
                        wait_q <= wait_q - 4'd1;
                    end
                end
                StResp:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a 2-wait-state instance and a 0-wait-state instance checked
// against a transaction-level model of RAM contents, load data and counters.
module tb_data_mem_responder;
    localparam int unsigned AW = 10;
`ifdef DATA_MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_mem_responder_if bus2 ();
    data_mem_responder_if bus0 ();

    data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(2)) dut2 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus2.slave)
    );
    data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) dut0 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus0.slave)
    );

    int tests = 0;
    int fails = 0;

    // Model state, index 0 = dut2, index 1 = dut0.
    logic [31:0] m_mem [2][1024];
    logic [31:0] m_din [2];
    int          m_rd  [2];
    int          m_wr  [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input bit s, input logic ren, input logic wen,
                           input logic [31:0] a, input logic [31:0] d);
        if (s) begin
            bus0.mem_ren = ren; bus0.mem_wen = wen; bus0.mem_addr = a; bus0.mem_dout = d;
        end else begin
            bus2.mem_ren = ren; bus2.mem_wen = wen; bus2.mem_addr = a; bus2.mem_dout = d;
        end
    endtask

    function automatic logic get_stall(input bit s);
        return s ? bus0.mem_stall : bus2.mem_stall;
    endfunction
    function automatic logic get_ack(input bit s);
        return s ? bus0.mem_ack : bus2.mem_ack;
    endfunction
    function automatic logic get_err(input bit s);
        return s ? bus0.mem_err : bus2.mem_err;
    endfunction
    function automatic logic [31:0] get_din(input bit s);
        return s ? bus0.mem_din : bus2.mem_din;
    endfunction
    function automatic logic [15:0] get_rd(input bit s);
        return s ? bus0.rd_count : bus2.rd_count;
    endfunction
    function automatic logic [15:0] get_wr(input bit s);
        return s ? bus0.wr_count : bus2.wr_count;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_din[i] = 32'd0; m_rd[i] = 0; m_wr[i] = 0;
        end
    endtask

    task automatic check_quiet(input bit s, input string tag);
        check({tag, "_stall"}, 32'(get_stall(s)), 32'd0);
        check({tag, "_ack"}, 32'(get_ack(s)), 32'd0);
    endtask

    // One access from the cycle the request appears until its RESP cycle; request left asserted.
    task automatic access(input bit s, input logic ren, input logic wen, input logic [31:0] a,
                          input logic [31:0] d, input bit drop);
        int unsigned ws;
        bit          mis;
        int          idx;
        ws = s ? 0 : 2;
        @(negedge clk);
        set_req(s, ren, wen, a, d);
        #1;
        check("stall_req", 32'(get_stall(s)), 32'd1);
        check("ack_req", 32'(get_ack(s)), 32'd0);
        for (int k = 1; k <= int'(ws); k++) begin
            @(negedge clk);
            if (drop && k == 1) set_req(s, 1'b0, 1'b0, $urandom, $urandom);
            #1;
            check("stall_wait", 32'(get_stall(s)), 32'd1);
            check("ack_wait", 32'(get_ack(s)), 32'd0);
        end
        mis = ALIGN && (a[1:0] != 2'b00);
        idx = int'(a[AW+1:2]);
        if (wen) begin
            if (!mis) begin
                m_mem[s][idx] = d;
                if (m_wr[s] < 65535) m_wr[s]++;
            end
        end else begin
            m_din[s] = mis ? 32'd0 : m_mem[s][idx];
            if (!mis && m_rd[s] < 65535) m_rd[s]++;
        end
        @(negedge clk);
        #1;
        check("stall_resp", 32'(get_stall(s)), 32'd0);
        check("ack_resp", 32'(get_ack(s)), 32'd1);
        check("err_resp", 32'(get_err(s)), 32'(mis));
        check("din_resp", get_din(s), m_din[s]);
        check("rd_count", 32'(get_rd(s)), 32'(m_rd[s]));
        check("wr_count", 32'(get_wr(s)), 32'(m_wr[s]));
    endtask

    task automatic idle(input bit s);
        @(negedge clk);
        set_req(s, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        check_quiet(s, "idle");
    endtask

    initial begin
        set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        model_reset();

        // Reset state, with a request visible to show stall is held low in reset.
        repeat (2) @(negedge clk);
        set_req(1'b0, 1'b1, 1'b0, 32'h40, 32'd0);
        #1;
        for (int s = 0; s < 2; s++) begin
            check_quiet(1'(s), "rst");
            check("rst_err", 32'(get_err(1'(s))), 32'd0);
            check("rst_din", get_din(1'(s)), 32'd0);
            check("rst_rd", 32'(get_rd(1'(s))), 32'd0);
            check("rst_wr", 32'(get_wr(1'(s))), 32'd0);
        end
        set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write then read with two wait states.
        access(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        idle(1'b0);
        access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        check("t1_read", get_din(1'b0), 32'hDEADBEEF);
        check("t1_rd", 32'(get_rd(1'b0)), 32'd1);
        idle(1'b0);

        // Zero wait states: back-to-back reads with ren held continuously.
        access(1'b1, 1'b0, 1'b1, 32'h0, 32'h11111111, 1'b0);
        idle(1'b1);
        access(1'b1, 1'b0, 1'b1, 32'h4, 32'h22222222, 1'b0);
        idle(1'b1);
        access(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        access(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
        check("t2_din", get_din(1'b1), 32'h22222222);
        idle(1'b1);
        idle(1'b1);
        check("t2_rd", 32'(get_rd(1'b1)), 32'd2);

        // Aliasing and simultaneous ren+wen.
        access(1'b0, 1'b0, 1'b1, 32'h0, 32'h1234, 1'b0);
        idle(1'b0);
        access(1'b0, 1'b1, 1'b0, 32'h1000, 32'h0, 1'b0);
        check("t3_alias", get_din(1'b0), 32'h1234);
        idle(1'b0);
        access(1'b0, 1'b1, 1'b1, 32'h8, 32'h5, 1'b0);
        check("t3_both_rd", 32'(get_rd(1'b0)), 32'd2);
        idle(1'b0);
        access(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
        check("t3_both_data", get_din(1'b0), 32'h5);
        idle(1'b0);

        // Request dropped during WAIT still completes.
        access(1'b0, 1'b0, 1'b1, 32'h20, 32'hA5, 1'b1);
        idle(1'b0);
        access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
        check("t4_drop", get_din(1'b0), 32'hA5);
        idle(1'b0);
        access(1'b0, 1'b0, 1'b1, 32'h24, 32'h77, 1'b0);
        idle(1'b0);

        // Reset in the middle of a write discards it.
        @(negedge clk);
        set_req(1'b0, 1'b0, 1'b1, 32'h24, 32'hBAD0BAD0);
        #1;
        check("t4_rst_stall0", 32'(get_stall(1'b0)), 32'd1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_quiet(1'b0, "t4_midrst");
        set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t4_rst_wr", 32'(get_wr(1'b0)), 32'd0);
        access(1'b0, 1'b1, 1'b0, 32'h24, 32'h0, 1'b0);
        check("t4_discard", get_din(1'b0), 32'h77);
        idle(1'b0);

        // Misaligned accesses.
        access(1'b0, 1'b0, 1'b1, 32'h22, 32'hCAFE, 1'b0);
        check("t6_err_wr", 32'(get_err(1'b0)), 32'(ALIGN));
        idle(1'b0);
        access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
        check("t6_word20", get_din(1'b0), ALIGN ? 32'hA5 : 32'hCAFE);
        idle(1'b0);
        access(1'b0, 1'b1, 1'b0, 32'h21, 32'h0, 1'b0);
        idle(1'b0);

        // Randomised traffic over a pre-written window of 16 words.
        for (int w = 0; w < 16; w++) begin
            access(1'b0, 1'b0, 1'b1, 32'h100 + 32'(w * 4), $urandom, 1'b0);
            idle(1'b0);
        end
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            int          op;
            a  = 32'h100 + 32'($urandom_range(15) * 4);
            if ($urandom_range(3) == 0) a[1:0] = 2'($urandom);
            if ($urandom_range(1) == 0) a[31:12] = 20'($urandom);
            op = int'($urandom_range(2));
            access(1'b0, op != 1, op != 0, a, $urandom, $urandom_range(3) == 0);
            repeat (1 + $urandom_range(1)) idle(1'b0);
        end

        // Write counter saturation.
        @(negedge clk);
        force dut2.wr_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut2.wr_cnt_q;
        m_wr[0] = 65534;
        #1;
        check("t5_forced", 32'(get_wr(1'b0)), 32'h0000FFFE);
        for (int n = 0; n < 3; n++) begin
            access(1'b0, 1'b0, 1'b1, 32'h30 + 32'(n * 4), 32'(n), 1'b0);
            idle(1'b0);
        end
        check("t5_sat", 32'(get_wr(1'b0)), 32'h0000FFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
